// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers, 3-stage pipeline, |Gx|+|Gy| output.
// Optional macro SOBEL_THRESH_EN adds a thresh port and binarises the magnitude.
`timescale 1ns/1ps
module sobel_stream #(
  parameter int DATA_W    = 8,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int MAG_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              sof_in,
  input  logic [DATA_W-1:0] pixel_in,
`ifdef SOBEL_THRESH_EN
  input  logic [DATA_W-1:0] thresh,
`endif
  output logic              valid_out,
  output logic              sof_out,
  output logic              eol_out,
  output logic              eof_out,
  output logic [DATA_W-1:0] pixel_out
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DATA_W + 3;
  localparam int MW = DATA_W + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [MW-1:0] SAT_MAX  = {4'b0000, {DATA_W{1'b1}}};

  logic [CW-1:0] col, pos_col;
  logic [RW-1:0] row, pos_row;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] top_px, mid_px;
  logic [DATA_W-1:0] win [3][3];

  logic s1_valid, s1_sof, s1_eol, s1_eof;
  logic s2_valid, s2_sof, s2_eol, s2_eof;
  logic signed [GW-1:0] gx_c, gy_c, gx, gy;
  logic [MW-1:0] mag_c, shifted_c;
  logic [DATA_W-1:0] sat_c, res_c;

  // sof_in overrides the running count so the accepted pixel lands at (0,0)
  assign pos_col = sof_in ? '0 : col;
  assign pos_row = sof_in ? '0 : row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (pos_col == COL_LAST) begin
        col <= '0;
        row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col <= pos_col + 1'b1;
        row <= pos_row;
      end
    end
  end

  assign top_px = lb1[pos_col];
  assign mid_px = lb0[pos_col];

  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb1[pos_col] <= mid_px;
      lb0[pos_col] <= pixel_in;
    end
  end

  // S1: window shift and output qualification for the incoming position
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
      if (valid_in) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= top_px;
        win[1][2] <= mid_px;
        win[2][2] <= pixel_in;
        if (pos_row >= ROW_TWO && pos_col >= COL_TWO) begin
          s1_valid <= 1'b1;
          s1_sof   <= (pos_row == ROW_TWO) && (pos_col == COL_TWO);
          s1_eol   <= (pos_col == COL_LAST);
          s1_eof   <= (pos_col == COL_LAST) && (pos_row == ROW_LAST);
        end
      end
    end
  end

  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
    return signed'({3'b000, p});
  endfunction

  function automatic logic [GW-1:0] absv(input logic signed [GW-1:0] g);
    return g[GW-1] ? -g : g;
  endfunction

  always_comb begin
    gx_c = ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2])
         - ext(win[0][0]) - (ext(win[1][0]) <<< 1) - ext(win[2][0]);
    gy_c = ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2])
         - ext(win[0][0]) - (ext(win[0][1]) <<< 1) - ext(win[0][2]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gx       <= '0;
      gy       <= '0;
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
      s2_eof   <= 1'b0;
    end else begin
      gx       <= gx_c;
      gy       <= gy_c;
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;
      s2_eof   <= s1_eof;
    end
  end

  always_comb begin
    mag_c     = {1'b0, absv(gx)} + {1'b0, absv(gy)};
    shifted_c = mag_c >> MAG_SHIFT;
    sat_c     = (shifted_c > SAT_MAX) ? {DATA_W{1'b1}} : shifted_c[DATA_W-1:0];
`ifdef SOBEL_THRESH_EN
    res_c     = (sat_c >= thresh) ? {DATA_W{1'b1}} : '0;
`else
    res_c     = sat_c;
`endif
  end

  // S3: everything but valid is forced to 0 on idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      eol_out   <= 1'b0;
      eof_out   <= 1'b0;
      pixel_out <= '0;
    end else begin
      valid_out <= s2_valid;
      sof_out   <= s2_valid & s2_sof;
      eol_out   <= s2_valid & s2_eol;
      eof_out   <= s2_valid & s2_eof;
      pixel_out <= s2_valid ? res_c : '0;
    end
  end

endmodule
